// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor step controller: FSM state encoding,
// default board-rate parameters and the step counter width.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_SEQ = 2'd0,
    IDLE    = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } ctrl_state_e;

  localparam int unsigned DB_LIMIT_DEF = 500000;
  localparam int unsigned DB_W_DEF     = 20;
  localparam int unsigned RUN_DIV_DEF  = 5000000;
  localparam int unsigned RUN_W_DEF    = 23;
  localparam int unsigned RST_HOLD_DEF = 4;
  localparam int unsigned STEP_W       = 16;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (v == '1) ? v : v + STEP_W'(1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer; exposes the
// debounced level and a one-cycle rising-edge event.
module button_debouncer
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned DB_LIMIT = DB_LIMIT_DEF,
  parameter int unsigned DB_W     = DB_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_d;
  logic [DB_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (r_sync2 != r_level) begin
        if (r_cnt == DB_W'(DB_LIMIT - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/proc_step_controller.sv
// Board front end: debounces buttons/switches and issues processor clock
// enables (single-step or free-run) plus a held reset. Optional: STEP_COUNT_EN.
module proc_step_controller
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned DB_LIMIT = DB_LIMIT_DEF,
  parameter int unsigned DB_W     = DB_W_DEF,
  parameter int unsigned RUN_DIV  = RUN_DIV_DEF,
  parameter int unsigned RUN_W    = RUN_W_DEF,
  parameter int unsigned RST_HOLD = RST_HOLD_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step_btn,
  input  logic              run_sw,
  input  logic              rst_btn,
  input  logic              show_sw,
  input  logic              instr_stop,
  output logic              proc_clk_en,
  output logic              proc_reset,
  output logic              data_show,
  output logic              running,
  output logic              halted,
  output logic [STEP_W-1:0] step_count
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  logic w_step_rise, w_step_lvl;
  logic w_rst_rise,  w_rst_lvl;
  logic w_run_rise,  w_run_lvl;
  logic w_show_rise, w_show_lvl;
  logic w_unused_ok;

  button_debouncer #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_step (
    .i_clk(clock), .i_rst_n(reset), .i_raw(step_btn), .o_level(w_step_lvl), .o_rise(w_step_rise)
  );
  button_debouncer #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_rst (
    .i_clk(clock), .i_rst_n(reset), .i_raw(rst_btn), .o_level(w_rst_lvl), .o_rise(w_rst_rise)
  );
  button_debouncer #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_run (
    .i_clk(clock), .i_rst_n(reset), .i_raw(run_sw), .o_level(w_run_lvl), .o_rise(w_run_rise)
  );
  button_debouncer #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_show (
    .i_clk(clock), .i_rst_n(reset), .i_raw(show_sw), .o_level(w_show_lvl), .o_rise(w_show_rise)
  );

  assign w_unused_ok = ^{w_step_lvl, w_rst_lvl, w_run_rise, w_show_rise};

  ctrl_state_e       r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [RUN_W-1:0]  r_div;
  logic              r_clk_en;
  logic              r_proc_reset;
  logic              w_leave_rst;
  logic              w_fire;

  assign w_leave_rst = (r_state == RST_SEQ) && (r_hold == HOLD_W'(RST_HOLD)) && !w_rst_rise;

  // Pulse issue decision; rst edge and instr_stop both suppress it.
  always_comb begin
    w_fire = 1'b0;
    if (!w_rst_rise && !instr_stop) begin
      case (r_state)
        IDLE:    w_fire = w_step_rise;
        RUN:     w_fire = w_run_lvl && (r_div == RUN_W'(RUN_DIV - 1));
        default: w_fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= RST_SEQ;
      r_hold       <= '0;
      r_div        <= '0;
      r_clk_en     <= 1'b0;
      r_proc_reset <= 1'b1;
    end else if (w_rst_rise) begin
      r_state      <= RST_SEQ;
      r_hold       <= '0;
      r_div        <= '0;
      r_clk_en     <= 1'b0;
      r_proc_reset <= 1'b1;
    end else begin
      r_clk_en <= w_fire;
      case (r_state)
        RST_SEQ: begin
          // Enable is forced so the processor samples its synchronous reset.
          if (w_leave_rst) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_proc_reset <= 1'b0;
            r_clk_en     <= 1'b0;
          end else begin
            r_hold       <= r_hold + HOLD_W'(1);
            r_proc_reset <= 1'b1;
            r_clk_en     <= 1'b1;
          end
        end
        IDLE: begin
          if (instr_stop) begin
            r_state <= DONE;
          end else if (w_run_lvl) begin
            r_state <= RUN;
            r_div   <= '0;
          end
        end
        RUN: begin
          if (instr_stop) begin
            r_state <= DONE;
            r_div   <= '0;
          end else if (!w_run_lvl) begin
            r_state <= IDLE;
            r_div   <= '0;
          end else if (w_fire) begin
            r_div <= '0;
          end else begin
            r_div <= r_div + RUN_W'(1);
          end
        end
        DONE: begin
          r_state <= DONE;
        end
      endcase
    end
  end

`ifdef STEP_COUNT_EN
  logic [STEP_W-1:0] r_step_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_step_cnt <= '0;
    end else if (w_leave_rst) begin
      r_step_cnt <= '0;
    end else if (w_fire) begin
      r_step_cnt <= sat_inc(r_step_cnt);
    end
  end

  assign step_count = r_step_cnt;
`else
  assign step_count = '0;
`endif

  assign proc_clk_en = r_clk_en;
  assign proc_reset  = r_proc_reset;
  assign data_show   = w_show_lvl;
  assign running     = (r_state == RUN);
  assign halted      = (r_state == DONE);

endmodule
